inv_key_schedule_seq: RTL

Iterative AES-128 decryption key feeder. Accepts the cipher key and runs the forward schedule internally to reach the round-10 key. It then walks the schedule backwards and emits round keys 10, 9, …, 0, one per valid/ready handshake. It sits between the key register and the inverse-cipher round datapath, which needs round keys in reverse order.

---
 rtl/inv_key_schedule_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/inv_key_schedule_seq.sv
// inv_key_schedule_seq: iterative AES-128 round-key feeder emitting round keys 10 down to 0
module inv_key_schedule_seq #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] cipher_key,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         last,
   output logic         busy
);

   if (NUM_ROUNDS != 10) begin : g_cfg_err
      $error("inv_key_schedule_seq: only NUM_ROUNDS = 10 (AES-128) is supported");
   end

   localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

   typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

   state_t       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [31:0]  w0, w1, w2, w3, w3p, sel, rot, sw, t;
   logic [127:0] fwd, bwd;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box as GF(2^8) inverse (a^254) followed by the AES affine transform
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] p, r;
      p = a;
      r = 8'h01;
      for (int k = 0; k < 7; k++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   assign {w0, w1, w2, w3} = key_q;
   assign w3p = w3 ^ w2;
   assign sel = (state_q == EMIT) ? w3p : w3;
   assign rot = {sel[23:0], sel[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      assign sw[8*i +: 8] = sbox(rot[8*i +: 8]);
   end

   assign t   = sw ^ {rcon(cnt_q), 24'h0};
   assign fwd = {w0 ^ t, w1 ^ w0 ^ t, w2 ^ w1 ^ w0 ^ t, w3 ^ w2 ^ w1 ^ w0 ^ t};
   assign bwd = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3p};

   // State, key and shared round counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         key_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: load, expand forward to round 10, then step backwards per handshake
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (key_valid) begin
            key_d   = cipher_key;
            cnt_d   = 4'd1;
            state_d = EXPAND;
         end
         EXPAND: begin
            key_d = fwd;
            if (cnt_q == LAST_RND) state_d = EMIT;
            else cnt_d = cnt_q + 4'd1;
         end
         EMIT: if (rk_ready) begin
            if (cnt_q != 4'd0) begin
               key_d = bwd;
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from registered state only
   always_comb begin
      key_ready = (state_q == IDLE);
      busy      = (state_q != IDLE);
      rk_valid  = (state_q == EMIT);
      round_idx = rk_valid ? cnt_q : 4'd0;
      last      = rk_valid && (cnt_q == 4'd0);
      round_key = key_q;
   end

endmodule
